// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C target port.
package i2c_pkg;

    localparam logic I2C_ACK    = 1'b0;
    localparam logic I2C_NACK   = 1'b1;
    localparam int   I2C_ADDR_W = 7;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        RX,
        RX_ACK,
        TX,
        TX_ACK,
        WAIT_STOP
    } state_t;

endpackage

// File: rtl/i2c_line_filter.sv
// Per-line input conditioning: 2-FF synchronizer, optional stability filter
// (I2C_SLAVE_FILTER_EN), previous-sample register and rise/fall strobes.
module i2c_line_filter #(
    parameter int FILT_LEN = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic pin,
    output logic level,
    output logic rise,
    output logic fall
);
    logic meta;
    logic sync;
    logic prev;

    if (FILT_LEN < 1) begin : g_bad_filt_len
        $error("FILT_LEN must be at least 1");
    end

    // Idle bus level is high, so reset to 1 to avoid phantom edges.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b1;
            sync <= 1'b1;
        end else begin
            meta <= pin;
            sync <= meta;
        end
    end

`ifdef I2C_SLAVE_FILTER_EN
    localparam int CW = $clog2(FILT_LEN + 1);
    logic [CW-1:0] cnt;
    logic          filt;

    // Down-counter reloads whenever the sample agrees with the output.
    always_ff @(posedge clk) begin
        if (rst) begin
            filt <= 1'b1;
            cnt  <= CW'(FILT_LEN - 1);
        end else if (sync == filt) begin
            cnt <= CW'(FILT_LEN - 1);
        end else if (cnt == '0) begin
            filt <= sync;
            cnt  <= CW'(FILT_LEN - 1);
        end else begin
            cnt <= cnt - 1'b1;
        end
    end

    assign level = filt;
`else
    assign level = sync;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            prev <= 1'b1;
        end else begin
            prev <= level;
        end
    end

    assign rise = level & ~prev;
    assign fall = ~level & prev;

endmodule

// File: rtl/i2c_slave_port.sv
// I2C target: START/STOP/address/data decode with open-drain SDA control.
// Build with I2C_SLAVE_FILTER_EN to insert the glitch filter on both lines.
module i2c_slave_port
    import i2c_pkg::*;
#(
    parameter logic [I2C_ADDR_W-1:0] SLAVE_ADDR = 7'd1,
    parameter int                    FILT_LEN   = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_o,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_req,
    output logic       rd_nack,
    output logic       busy
);
    // state     | meaning
    // IDLE      | bus ignored until START
    // ADDR      | shifting address + R/W byte
    // ADDR_ACK  | driving address ACK
    // RX        | receiving a write byte
    // RX_ACK    | driving data ACK
    // TX        | shifting a read byte out
    // TX_ACK    | sampling master ACK/NACK
    // WAIT_STOP | not addressed, waiting for START/STOP

    logic scl_lvl, scl_rise, scl_fall;
    logic sda_lvl, sda_rise, sda_fall;

    i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_scl (
        .clk  (clk),
        .rst  (rst),
        .pin  (scl_i),
        .level(scl_lvl),
        .rise (scl_rise),
        .fall (scl_fall)
    );

    i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_sda (
        .clk  (clk),
        .rst  (rst),
        .pin  (sda_i),
        .level(sda_lvl),
        .rise (sda_rise),
        .fall (sda_fall)
    );

    // SCL must be high now and in the previous sample, i.e. high with no rise.
    logic start, stop;
    assign start = sda_fall & scl_lvl & ~scl_rise;
    assign stop  = sda_rise & scl_lvl & ~scl_rise;

    state_t     state, state_n;
    logic [2:0] bit_cnt, bit_cnt_n;
    logic [7:0] shift, shift_n;
    logic       addr_done, addr_done_n;
    logic       sda_o_n, rx_valid_n, tx_req_n, rd_nack_n, busy_n;
    logic [7:0] rx_data_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            shift     <= '0;
            addr_done <= 1'b0;
            sda_o     <= 1'b1;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            tx_req    <= 1'b0;
            rd_nack   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_n;
            bit_cnt   <= bit_cnt_n;
            shift     <= shift_n;
            addr_done <= addr_done_n;
            sda_o     <= sda_o_n;
            rx_data   <= rx_data_n;
            rx_valid  <= rx_valid_n;
            tx_req    <= tx_req_n;
            rd_nack   <= rd_nack_n;
            busy      <= busy_n;
        end
    end

    always_comb begin
        state_n     = state;
        bit_cnt_n   = bit_cnt;
        shift_n     = shift;
        addr_done_n = addr_done;
        sda_o_n     = sda_o;
        rx_data_n   = rx_data;
        rx_valid_n  = 1'b0;
        tx_req_n    = 1'b0;
        rd_nack_n   = 1'b0;
        busy_n      = busy;

        if (start) begin
            state_n     = ADDR;
            bit_cnt_n   = '0;
            addr_done_n = 1'b0;
            sda_o_n     = 1'b1;
            busy_n      = 1'b0;
        end else if (stop) begin
            state_n = IDLE;
            sda_o_n = 1'b1;
            busy_n  = 1'b0;
        end else begin
            case (state)
                ADDR: begin
                    if (scl_rise && !addr_done) begin
                        shift_n   = {shift[6:0], sda_lvl};
                        bit_cnt_n = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            if (shift[6:0] == SLAVE_ADDR) begin
                                addr_done_n = 1'b1;
                            end else begin
                                state_n = WAIT_STOP;
                            end
                        end
                    end else if (scl_fall && addr_done) begin
                        sda_o_n = I2C_ACK;
                        busy_n  = 1'b1;
                        state_n = ADDR_ACK;
                    end
                end
                ADDR_ACK: begin
                    if (scl_fall) begin
                        bit_cnt_n = '0;
                        if (shift[0]) begin
                            tx_req_n = 1'b1;
                            shift_n  = tx_data;
                            sda_o_n  = tx_data[7];
                            state_n  = TX;
                        end else begin
                            sda_o_n = 1'b1;
                            state_n = RX;
                        end
                    end
                end
                // RX is entered on a fall, so a fall with the counter at 0
                // can only follow the 8th rise.
                RX: begin
                    if (scl_rise) begin
                        shift_n   = {shift[6:0], sda_lvl};
                        bit_cnt_n = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            rx_data_n  = {shift[6:0], sda_lvl};
                            rx_valid_n = 1'b1;
                        end
                    end else if (scl_fall && bit_cnt == 3'd0) begin
                        sda_o_n = I2C_ACK;
                        state_n = RX_ACK;
                    end
                end
                RX_ACK: begin
                    if (scl_fall) begin
                        sda_o_n = 1'b1;
                        state_n = RX;
                    end
                end
                TX: begin
                    if (scl_fall) begin
                        if (bit_cnt == 3'd7) begin
                            sda_o_n = 1'b1;
                            state_n = TX_ACK;
                        end else begin
                            sda_o_n   = shift[6];
                            shift_n   = {shift[6:0], 1'b0};
                            bit_cnt_n = bit_cnt + 3'd1;
                        end
                    end
                end
                TX_ACK: begin
                    if (scl_rise && sda_lvl == I2C_NACK) begin
                        rd_nack_n = 1'b1;
                        busy_n    = 1'b0;
                        state_n   = WAIT_STOP;
                    end else if (scl_fall) begin
                        tx_req_n  = 1'b1;
                        shift_n   = tx_data;
                        sda_o_n   = tx_data[7];
                        bit_cnt_n = '0;
                        state_n   = TX;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_slave_port.sv
// Bench for i2c_slave_port: bus-level master, byte-source model and an
// event scoreboard fed by the transaction model and drained by a monitor.
module tb_i2c_slave_port;
    import i2c_pkg::*;

    localparam logic [6:0] SADDR = 7'd1;
    localparam int         Q     = 4;
    localparam logic [1:0] EV_RX = 2'd0, EV_TX = 2'd1, EV_NACK = 2'd2;
`ifdef I2C_SLAVE_FILTER_EN
    localparam bit GLITCH_STARTS = 1'b0;
`else
    localparam bit GLITCH_STARTS = 1'b1;
`endif

    typedef struct packed {
        logic [1:0] kind;
        logic [7:0] data;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       scl_m, sda_m;
    logic       sda_o, rx_valid, tx_req, rd_nack, busy;
    logic [7:0] rx_data, tx_data;
    logic       bus_sda;

    ev_t        exp_q[$];
    logic [7:0] src_mem [256];
    logic [7:0] byte_buf [4];
    int         src_idx = 0, model_idx = 0;
    int         checks = 0, errors = 0, release_viol = 0;
    bit         watch_release = 1'b0, glitch_win = 1'b0, saw_addr = 1'b0;

    assign bus_sda = sda_m & sda_o;
    assign tx_data = src_mem[src_idx[7:0]];

    always #5 clk = ~clk;

    i2c_slave_port #(.SLAVE_ADDR(SADDR), .FILT_LEN(3)) dut (
        .clk     (clk),
        .rst     (rst),
        .scl_i   (scl_m),
        .sda_i   (bus_sda),
        .sda_o   (sda_o),
        .rx_data (rx_data),
        .rx_valid(rx_valid),
        .tx_data (tx_data),
        .tx_req  (tx_req),
        .rd_nack (rd_nack),
        .busy    (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_ev(input logic [1:0] kind, input logic [7:0] data);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event: kind %0d data %0h with nothing expected", kind, data);
        end else begin
            e = exp_q.pop_front();
            if (e.kind !== kind || e.data !== data) begin
                errors++;
                $display("FAIL event: got kind %0d data %0h expected kind %0d data %0h",
                         kind, data, e.kind, e.data);
            end
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (int'(rx_valid) + int'(tx_req) + int'(rd_nack) > 1) begin
                checks++;
                errors++;
                $display("FAIL pulse_overlap: rx_valid %b tx_req %b rd_nack %b", rx_valid, tx_req, rd_nack);
            end
            if (rx_valid) check_ev(EV_RX, rx_data);
            if (tx_req)   check_ev(EV_TX, tx_data);
            if (rd_nack)  check_ev(EV_NACK, 8'h00);
            if (watch_release && !sda_o) release_viol++;
            if (glitch_win && dut.state == ADDR) saw_addr = 1'b1;
        end
    end

    // Byte source advances only after the tx_req cycle has ended.
    always @(negedge clk) begin
        if (!rst && tx_req) begin
            @(posedge clk);
            #1;
            src_idx = src_idx + 1;
        end
    end

    initial begin
        repeat (90000) @(posedge clk);
        $display("FAIL watchdog: simulation exceeded cycle budget");
        $fatal(1, "watchdog");
    end

    task automatic wclk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bit_xfer(input logic b, output logic s);
        wclk(Q); sda_m = b;
        wclk(Q); scl_m = 1'b1;
        wclk(Q); s = bus_sda;
        wclk(Q); scl_m = 1'b0;
    endtask

    task automatic do_start();
        if (scl_m) begin
            sda_m = 1'b0; wclk(2*Q); scl_m = 1'b0;
        end else begin
            wclk(Q); sda_m = 1'b1;
            wclk(Q); scl_m = 1'b1;
            wclk(2*Q); sda_m = 1'b0;
            wclk(2*Q); scl_m = 1'b0;
        end
    endtask

    task automatic do_stop();
        wclk(Q); sda_m = 1'b0;
        wclk(Q); scl_m = 1'b1;
        wclk(2*Q); sda_m = 1'b1;
        wclk(2*Q);
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) bit_xfer(d[i], s);
        bit_xfer(1'b1, ack);
    endtask

    task automatic read_byte(input logic mack, output logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            bit_xfer(1'b1, s);
            d[i] = s;
        end
        bit_xfer(mack, s);
    endtask

    // Reference behaviour: a matching address gets every 9th clock ACKed and
    // one event per byte; anything else leaves SDA released with no events.
    task automatic transaction(input logic [6:0] addr, input logic rw, input int n, input bit end_stop);
        bit         hit;
        logic       ack;
        logic [7:0] d;
        hit = (addr == SADDR);
        if (hit) begin
            if (!rw) begin
                for (int i = 0; i < n; i++) exp_q.push_back({EV_RX, byte_buf[i]});
            end else begin
                for (int i = 0; i < n; i++) exp_q.push_back({EV_TX, src_mem[model_idx + i]});
                exp_q.push_back({EV_NACK, 8'h00});
            end
        end
        do_start();
        watch_release = !hit;
        write_byte({addr, rw}, ack);
        check("addr_ack", ack, hit ? 0 : 1);
        if (hit) check("busy_set", busy, 1);
        if (!rw) begin
            for (int i = 0; i < n; i++) begin
                write_byte(byte_buf[i], ack);
                check("data_ack", ack, hit ? 0 : 1);
            end
            if (hit) check("rx_data", rx_data, byte_buf[n-1]);
        end else if (hit) begin
            for (int i = 0; i < n; i++) begin
                read_byte(i == n - 1, d);
                check("rd_byte", d, src_mem[model_idx]);
                model_idx++;
            end
            check("busy_after_nack", busy, 0);
        end
        if (end_stop) begin
            do_stop();
            wclk(8);
            check("busy_after_stop", busy, 0);
        end
        watch_release = 1'b0;
        if (!hit) check("sda_released", release_viol, 0);
        release_viol = 0;
        check("sb_empty", exp_q.size(), 0);
    endtask

    initial begin
        logic ack, s;
        for (int i = 0; i < 256; i++) src_mem[i] = 8'($urandom_range(0, 255));
        rst = 1'b1; scl_m = 1'b1; sda_m = 1'b1;
        wclk(5);
        check("rst_sda_o", sda_o, 1);
        check("rst_rx_data", rx_data, 8'h00);
        check("rst_pulses", {rx_valid, tx_req, rd_nack}, 3'b000);
        check("rst_busy", busy, 0);
        rst = 1'b0;
        wclk(8);

        byte_buf[0] = 8'h14;
        transaction(SADDR, 1'b0, 1, 1'b1);

        src_mem[model_idx] = 8'hA5; src_mem[model_idx + 1] = 8'h3C;
        transaction(SADDR, 1'b1, 2, 1'b1);

        byte_buf[0] = 8'h55;
        transaction(7'h02, 1'b0, 1, 1'b1);

        byte_buf[0] = 8'h11;
        transaction(SADDR, 1'b0, 1, 1'b0);
        src_mem[model_idx] = 8'h7E;
        transaction(SADDR, 1'b1, 1, 1'b1);

        // Reset in the middle of a write byte.
        do_start();
        write_byte({SADDR, 1'b0}, ack);
        check("reset_case_addr_ack", ack, 0);
        bit_xfer(1'b1, s); bit_xfer(1'b0, s); bit_xfer(1'b1, s); bit_xfer(1'b0, s);
        rst = 1'b1;
        wclk(1);
        rst = 1'b0;
        check("reset_sda_o", sda_o, 1);
        check("reset_busy", busy, 0);
        watch_release = 1'b1;
        for (int i = 0; i < 4; i++) bit_xfer(1'b0, s);
        bit_xfer(1'b1, ack);
        watch_release = 1'b0;
        check("reset_ignored_ack", ack, 1);
        check("reset_sda_released", release_viol, 0);
        release_viol = 0;
        byte_buf[0] = 8'h5A;
        transaction(SADDR, 1'b0, 1, 1'b1);

        // One-clock SDA glitch while SCL is high.
        glitch_win = 1'b1;
        sda_m = 1'b0;
        wclk(1);
        sda_m = 1'b1;
        wclk(20);
        glitch_win = 1'b0;
        check("glitch_start", saw_addr, GLITCH_STARTS);

        for (int t = 0; t < 24; t++) begin
            logic [6:0] a;
            logic       rw;
            int         n;
            bit         es;
            a  = ($urandom_range(0, 2) != 0) ? SADDR : 7'($urandom_range(0, 127));
            rw = 1'($urandom_range(0, 1));
            n  = $urandom_range(1, 3);
            for (int i = 0; i < 4; i++) byte_buf[i] = 8'($urandom_range(0, 255));
            es = (t == 23) || ($urandom_range(0, 1) == 1);
            transaction(a, rw, n, es);
        end

        wclk(10);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
